// File: rtl/rf_sched_pkg.sv
// Shared widths and types for the register-file write scheduler.
// The hold buffer holds at most one link write that lost arbitration to writeback.
package rf_sched_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int NREG  = 32;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        HOLD_EMPTY,
        HOLD_FULL
    } hold_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending/stale tracking for outstanding MDU results.
// A pending register whose value is overwritten by wb or link goes stale, so the late MDU result is dropped.
module rf_scoreboard #(
    parameter int REG_W = 5,
    parameter int NREG  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_valid_i,
    input  logic [REG_W-1:0] set_reg_i,
    input  logic             clr_valid_i,
    input  logic [REG_W-1:0] clr_reg_i,
    input  logic             mark_valid_i,
    input  logic [REG_W-1:0] mark_reg_i,
    input  logic [REG_W-1:0] query_reg_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    output logic             query_stale_o,
    output logic             rs1_pending_o,
    output logic             rs2_pending_o
);

    logic [NREG-1:0] pending_q, pending_d;
    logic [NREG-1:0] stale_q, stale_d;
    logic [NREG-1:0] setVec, clrVec, markVec;

    // A new issue outranks a same-cycle retire of the same register, leaving it pending and fresh.
    always_comb begin
        setVec  = '0;
        clrVec  = '0;
        markVec = '0;
        if (set_valid_i && (set_reg_i != '0)) setVec[set_reg_i] = 1'b1;
        if (clr_valid_i)  clrVec[clr_reg_i]   = 1'b1;
        if (mark_valid_i) markVec[mark_reg_i] = 1'b1;
        pending_d = (pending_q & ~clrVec) | setVec;
        stale_d   = (stale_q | (markVec & pending_q)) & ~clrVec & ~setVec;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            stale_q   <= '0;
        end else begin
            pending_q <= pending_d;
            stale_q   <= stale_d;
        end
    end

    assign query_stale_o = stale_q[query_reg_i];
    assign rs1_pending_o = pending_q[rs1_i];
    assign rs2_pending_o = pending_q[rs2_i];

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the single register-file write port among writeback, link and MDU results,
// holding one link write behind writeback and stalling decode on outstanding MDU destinations.
module rf_write_scheduler #(
    parameter int XLEN  = rf_sched_pkg::XLEN,
    parameter int REG_W = rf_sched_pkg::REG_W,
    parameter int NREG  = rf_sched_pkg::NREG
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_reg,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             link_valid,
    input  logic [REG_W-1:0] link_reg,
    input  logic [XLEN-1:0]  link_data,
    output logic             link_busy,
    input  logic             mdu_valid,
    input  logic [REG_W-1:0] mdu_reg,
    input  logic [XLEN-1:0]  mdu_data,
    output logic             mdu_ready,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_reg,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             hazard_stall,
    output logic             rf_we,
    output logic [REG_W-1:0] rf_waddr,
    output logic [XLEN-1:0]  rf_wdata
);

    import rf_sched_pkg::*;

    hold_state_t      holdState_q;
    logic [REG_W-1:0] holdReg_q;
    logic [XLEN-1:0]  holdData_q;

    logic holdFull, mduXfer, markValid, mduStale;
    logic rs1Pending, rs2Pending, rs1Hit, rs2Hit;

    assign holdFull  = (holdState_q == HOLD_FULL);
    assign link_busy = holdFull;
    assign mdu_ready = ~reset & ~wb_valid & ~holdFull & ~link_valid;
    assign mduXfer   = mdu_valid & mdu_ready;

    // Fixed priority: wb, held link, incoming link, MDU. Writes to r0 and stale MDU results are consumed silently.
    always_comb begin
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        markValid = 1'b0;
        if (wb_valid) begin
            rf_we     = (wb_reg != ZERO_REG);
            rf_waddr  = wb_reg;
            rf_wdata  = wb_data;
            markValid = 1'b1;
        end else if (holdFull) begin
            rf_we     = (holdReg_q != ZERO_REG);
            rf_waddr  = holdReg_q;
            rf_wdata  = holdData_q;
            markValid = 1'b1;
        end else if (link_valid) begin
            rf_we     = (link_reg != ZERO_REG);
            rf_waddr  = link_reg;
            rf_wdata  = link_data;
            markValid = 1'b1;
        end else if (mduXfer) begin
            rf_we     = (mdu_reg != ZERO_REG) && !mduStale;
            rf_waddr  = mdu_reg;
            rf_wdata  = mdu_data;
        end
        if (reset) begin
            rf_we     = 1'b0;
            markValid = 1'b0;
        end
    end

    // A link request arriving while the buffer is full is illegal and simply dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            holdState_q <= HOLD_EMPTY;
            holdReg_q   <= '0;
            holdData_q  <= '0;
        end else begin
            case (holdState_q)
                HOLD_EMPTY: begin
                    if (link_valid && wb_valid) begin
                        holdState_q <= HOLD_FULL;
                        holdReg_q   <= link_reg;
                        holdData_q  <= link_data;
                    end
                end
                HOLD_FULL: begin
                    if (!wb_valid) holdState_q <= HOLD_EMPTY;
                end
                default: holdState_q <= HOLD_EMPTY;
            endcase
        end
    end

    rf_scoreboard #(
        .REG_W (REG_W),
        .NREG  (NREG)
    ) u_scoreboard (
        .clock         (clock),
        .reset         (reset),
        .set_valid_i   (issue_valid),
        .set_reg_i     (issue_reg),
        .clr_valid_i   (mduXfer),
        .clr_reg_i     (mdu_reg),
        .mark_valid_i  (markValid),
        .mark_reg_i    (rf_waddr),
        .query_reg_i   (mdu_reg),
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .query_stale_o (mduStale),
        .rs1_pending_o (rs1Pending),
        .rs2_pending_o (rs2Pending)
    );

    assign rs1Hit = (rs1 != ZERO_REG) && (rs1Pending || (holdFull && (holdReg_q == rs1)));
    assign rs2Hit = (rs2 != ZERO_REG) && (rs2Pending || (holdFull && (holdReg_q == rs2)));
    assign hazard_stall = ~reset & (rs1Hit | rs2Hit);

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: expected register-file writes are queued as stimulus
// is driven and matched against every rf_we pulse; handshake, busy and stall outputs are checked inline.
module tb_rf_write_scheduler;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clock;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        link_valid;
    logic [4:0]  link_reg;
    logic [31:0] link_data;
    logic        link_busy;
    logic        mdu_valid;
    logic [4:0]  mdu_reg;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks   = 0;
    int failures = 0;

    wr_t         expQ[$];
    logic [31:0] rfObs[32];
    int          writeCount[32];

    rf_write_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .link_valid   (link_valid),
        .link_reg     (link_reg),
        .link_data    (link_data),
        .link_busy    (link_busy),
        .mdu_valid    (mdu_valid),
        .mdu_reg      (mdu_reg),
        .mdu_data     (mdu_data),
        .mdu_ready    (mdu_ready),
        .issue_valid  (issue_valid),
        .issue_reg    (issue_reg),
        .rs1          (rs1),
        .rs2          (rs2),
        .hazard_stall (hazard_stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    // Free-running 10ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Every observed write must be the oldest expected write; an unexpected write is a failure.
    always @(negedge clock) begin
        wr_t e;
        if (rf_we) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write: got reg %0d data %h, want no write", rf_waddr, rf_wdata);
            end else begin
                e = expQ.pop_front();
                if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
                    failures++;
                    $display("[TB] FAIL write_order: got reg %0d data %h, want reg %0d data %h",
                             rf_waddr, rf_wdata, e.addr, e.data);
                end
            end
            rfObs[rf_waddr] = rf_wdata;
            writeCount[rf_waddr]++;
        end
        if (link_valid && link_busy) begin
            failures++;
            $display("[TB] FAIL illegal_link: link_valid=1 while link_busy=1");
        end
    end

    // Hard stop so a wedged run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idleInputs();
        wb_valid    = 1'b0; wb_reg   = '0; wb_data   = '0;
        link_valid  = 1'b0; link_reg = '0; link_data = '0;
        mdu_valid   = 1'b0; mdu_reg  = '0; mdu_data  = '0;
        issue_valid = 1'b0; issue_reg = '0;
        rs1 = '0; rs2 = '0;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic pushWrite(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic checkQueueEmpty(input string name);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_drain: got %0d pending writes, want 0", name, expQ.size());
        end
    endtask

    // Outputs must be quiet while reset is held, even with every request asserted.
    task automatic test_reset();
        reset = 1'b1;
        idleInputs();
        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h1;
        link_valid = 1'b1; link_reg = 5'd6;
        mdu_valid = 1'b1; mdu_reg = 5'd7;
        issue_valid = 1'b1; issue_reg = 5'd9;
        rs1 = 5'd9; rs2 = 5'd6;
        #3;
        checks++;
        if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %b want 0", rf_we); end
        checks++;
        if (mdu_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b want 0", mdu_ready); end
        checks++;
        if (link_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", link_busy); end
        checks++;
        if (hazard_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b want 0", hazard_stall); end
        idleInputs();
        @(negedge clock);
        reset = 1'b0;
        nextCycle();
    endtask

    task automatic test_direct();
        logic [4:0]  r;
        logic [31:0] d;
        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h11111111;
        pushWrite(5'd5, 32'h11111111);
        @(negedge clock);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin
            failures++;
            $display("[TB] FAIL direct_wb: got we=%b addr=%0d want we=1 addr=5", rf_we, rf_waddr);
        end
        nextCycle();
        wb_reg = 5'd0; wb_data = 32'hCAFEF00D;
        @(negedge clock);
        checks++;
        if (rf_we !== 1'b0) begin failures++; $display("[TB] FAIL direct_r0: got we=%b want 0", rf_we); end
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            r = 5'($urandom_range(1, 31));
            d = $urandom;
            wb_reg = r; wb_data = d;
            pushWrite(r, d);
        end
        nextCycle();
        idleInputs();
        link_valid = 1'b1; link_reg = 5'd15; link_data = 32'h0000F00F;
        pushWrite(5'd15, 32'h0000F00F);
        @(negedge clock);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd15) begin
            failures++;
            $display("[TB] FAIL direct_link: got we=%b addr=%0d want we=1 addr=15", rf_we, rf_waddr);
        end
        nextCycle();
        idleInputs();
        checks++;
        if (link_busy !== 1'b0) begin failures++; $display("[TB] FAIL direct_link_busy: got %b want 0", link_busy); end
        nextCycle();
        checkQueueEmpty("direct");
    endtask

    // Link loses to wb, waits through another wb cycle, then drains with no wb present.
    task automatic test_collision();
        wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h33333333;
        link_valid = 1'b1; link_reg = 5'd31; link_data = 32'h00400008;
        pushWrite(5'd3, 32'h33333333);
        @(negedge clock);
        checks++;
        if (rf_waddr !== 5'd3 || link_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL coll_c0: got addr=%0d busy=%b want addr=3 busy=0", rf_waddr, link_busy);
        end
        nextCycle();
        link_valid = 1'b0;
        wb_reg = 5'd7; wb_data = 32'h77777777;
        pushWrite(5'd7, 32'h77777777);
        @(negedge clock);
        checks++;
        if (link_busy !== 1'b1 || rf_waddr !== 5'd7) begin
            failures++;
            $display("[TB] FAIL coll_c1: got busy=%b addr=%0d want busy=1 addr=7", link_busy, rf_waddr);
        end
        nextCycle();
        idleInputs();
        rs1 = 5'd31;
        pushWrite(5'd31, 32'h00400008);
        @(negedge clock);
        checks++;
        if (link_busy !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h00400008) begin
            failures++;
            $display("[TB] FAIL coll_c2: got busy=%b we=%b addr=%0d data=%h want busy=1 we=1 addr=31 data=00400008",
                     link_busy, rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if (hazard_stall !== 1'b1) begin failures++; $display("[TB] FAIL coll_held_stall: got %b want 1", hazard_stall); end
        nextCycle();
        @(negedge clock);
        checks++;
        if (link_busy !== 1'b0 || rf_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL coll_c3: got busy=%b we=%b want busy=0 we=0", link_busy, rf_we);
        end
        idleInputs();
        nextCycle();
        checkQueueEmpty("collision");
    endtask

    task automatic test_mdu_backpressure();
        mdu_valid = 1'b1; mdu_reg = 5'd8; mdu_data = 32'h88888888;
        wb_valid = 1'b1; wb_reg = 5'd10; wb_data = 32'h10101010;
        pushWrite(5'd10, 32'h10101010);
        @(negedge clock);
        checks++;
        if (mdu_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_c0_ready: got %b want 0", mdu_ready); end
        nextCycle();
        wb_reg = 5'd11; wb_data = 32'h11110000;
        pushWrite(5'd11, 32'h11110000);
        @(negedge clock);
        checks++;
        if (mdu_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_c1_ready: got %b want 0", mdu_ready); end
        nextCycle();
        wb_valid = 1'b0;
        pushWrite(5'd8, 32'h88888888);
        @(negedge clock);
        checks++;
        if (mdu_ready !== 1'b1 || rf_we !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_c2: got ready=%b we=%b want ready=1 we=1", mdu_ready, rf_we);
        end
        nextCycle();
        mdu_reg = 5'd13; mdu_data = 32'h13131313;
        link_valid = 1'b1; link_reg = 5'd16; link_data = 32'h16161616;
        pushWrite(5'd16, 32'h16161616);
        @(negedge clock);
        checks++;
        if (mdu_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_link_ready: got %b want 0", mdu_ready); end
        nextCycle();
        link_valid = 1'b0;
        pushWrite(5'd13, 32'h13131313);
        @(negedge clock);
        checks++;
        if (mdu_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_after_link_ready: got %b want 1", mdu_ready); end
        nextCycle();
        idleInputs();
        nextCycle();
        checks++;
        if (writeCount[8] != 1) begin failures++; $display("[TB] FAIL bp_reg8_count: got %0d want 1", writeCount[8]); end
        checkQueueEmpty("backpressure");
    endtask

    task automatic test_hazard();
        issue_valid = 1'b1; issue_reg = 5'd9; rs1 = 5'd9;
        @(negedge clock);
        checks++;
        if (hazard_stall !== 1'b0) begin failures++; $display("[TB] FAIL hz_issue_cycle: got %b want 0", hazard_stall); end
        nextCycle();
        issue_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (hazard_stall !== 1'b1) begin failures++; $display("[TB] FAIL hz_rs1: got %b want 1", hazard_stall); end
        nextCycle();
        rs1 = 5'd0; rs2 = 5'd9;
        @(negedge clock);
        checks++;
        if (hazard_stall !== 1'b1) begin failures++; $display("[TB] FAIL hz_rs2: got %b want 1", hazard_stall); end
        nextCycle();
        rs2 = 5'd0;
        @(negedge clock);
        checks++;
        if (hazard_stall !== 1'b0) begin failures++; $display("[TB] FAIL hz_r0: got %b want 0", hazard_stall); end
        nextCycle();
        rs1 = 5'd9;
        mdu_valid = 1'b1; mdu_reg = 5'd9; mdu_data = 32'h99999999;
        pushWrite(5'd9, 32'h99999999);
        @(negedge clock);
        checks++;
        if (hazard_stall !== 1'b1 || mdu_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hz_xfer: got stall=%b ready=%b want stall=1 ready=1", hazard_stall, mdu_ready);
        end
        nextCycle();
        mdu_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (hazard_stall !== 1'b0) begin failures++; $display("[TB] FAIL hz_cleared: got %b want 0", hazard_stall); end
        nextCycle();
        // Issue and retire of r12 in the same cycle keeps r12 pending.
        rs1 = 5'd12;
        issue_valid = 1'b1; issue_reg = 5'd12;
        nextCycle();
        mdu_valid = 1'b1; mdu_reg = 5'd12; mdu_data = 32'h12121212;
        pushWrite(5'd12, 32'h12121212);
        nextCycle();
        issue_valid = 1'b0; mdu_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (hazard_stall !== 1'b1) begin failures++; $display("[TB] FAIL hz_issue_wins: got %b want 1", hazard_stall); end
        nextCycle();
        mdu_valid = 1'b1; mdu_data = 32'h13130000;
        pushWrite(5'd12, 32'h13130000);
        nextCycle();
        mdu_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (hazard_stall !== 1'b0) begin failures++; $display("[TB] FAIL hz_r12_cleared: got %b want 0", hazard_stall); end
        idleInputs();
        nextCycle();
        checkQueueEmpty("hazard");
    endtask

    task automatic test_stale();
        issue_valid = 1'b1; issue_reg = 5'd4;
        nextCycle();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'hAAAA0000;
        pushWrite(5'd4, 32'hAAAA0000);
        nextCycle();
        wb_valid = 1'b0;
        mdu_valid = 1'b1; mdu_reg = 5'd4; mdu_data = 32'hDEADBEEF;
        @(negedge clock);
        checks++;
        if (mdu_ready !== 1'b1 || rf_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stale_drop: got ready=%b we=%b want ready=1 we=0", mdu_ready, rf_we);
        end
        nextCycle();
        idleInputs();
        rs1 = 5'd4;
        @(negedge clock);
        checks++;
        if (hazard_stall !== 1'b0) begin failures++; $display("[TB] FAIL stale_stall: got %b want 0", hazard_stall); end
        checks++;
        if (rfObs[4] !== 32'hAAAA0000) begin failures++; $display("[TB] FAIL stale_value: got %h want aaaa0000", rfObs[4]); end
        nextCycle();
        idleInputs();
        checkQueueEmpty("stale");
    endtask

    // Reset with a full hold buffer and an outstanding MDU op must silence everything and lose the held link.
    task automatic test_reset_mid();
        issue_valid = 1'b1; issue_reg = 5'd6;
        nextCycle();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h22222222;
        link_valid = 1'b1; link_reg = 5'd20; link_data = 32'h20202020;
        pushWrite(5'd2, 32'h22222222);
        nextCycle();
        idleInputs();
        rs1 = 5'd6; rs2 = 5'd20;
        #1;
        checks++;
        if (link_busy !== 1'b1 || hazard_stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rmid_pre: got busy=%b stall=%b want busy=1 stall=1", link_busy, hazard_stall);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (link_busy !== 1'b0 || hazard_stall !== 1'b0 || rf_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rmid_now: got busy=%b stall=%b we=%b want 0 0 0", link_busy, hazard_stall, rf_we);
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (rf_we !== 1'b0 || hazard_stall !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rmid_after%0d: got we=%b stall=%b want 0 0", i, rf_we, hazard_stall);
            end
        end
        nextCycle();
        checkQueueEmpty("reset_mid");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rfObs[i] = '0;
            writeCount[i] = 0;
        end
        test_reset();
        test_direct();
        test_collision();
        test_mdu_backpressure();
        test_hazard();
        test_stale();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
